// File: rtl/console_pkg.sv
// Shared definitions for the console write path: screen geometry, control codes and FSM states.
package console_pkg;

    localparam int ADDR_W = 13;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 6;
    localparam int COLS   = 100;
    localparam int ROWS   = 60;

    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_FF    = 8'h0C;
    localparam logic [7:0] CHAR_CR    = 8'h0D;

    localparam logic [COL_W-1:0]  LAST_COL       = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW       = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ROW_CLEAR_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ALL_CLEAR_LAST = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor position for the console writer; rowBase tracks row*COLS incrementally so no multiplier is needed.
module console_cursor
    import console_pkg::*;
(
    input  logic              writeClock,
    input  logic              resetN,
    input  logic              inc,
    input  logic              dec,
    input  logic              cr,
    input  logic              newLine,
    input  logic              home,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] rowBase,
    output logic              lastCol
);

    logic advance;

    assign lastCol = (col == LAST_COL);
    // A printable in the last column behaves like a newline after its write
    assign advance = newLine | (inc & lastCol);

    always_ff @(posedge writeClock or negedge resetN) begin
        if (!resetN) begin
            col     <= '0;
            row     <= '0;
            rowBase <= '0;
        end else if (home) begin
            col     <= '0;
            row     <= '0;
            rowBase <= '0;
        end else begin
            if (advance || cr) begin
                col <= '0;
            end else if (inc) begin
                col <= col + COL_W'(1);
            end else if (dec && (col != '0)) begin
                col <= col - COL_W'(1);
            end

            if (advance) begin
                if (row == LAST_ROW) begin
                    row     <= '0;
                    rowBase <= '0;
                end else begin
                    row     <= row + ROW_W'(1);
                    rowBase <= rowBase + ROW_STRIDE;
                end
            end
        end
    end

endmodule

// File: rtl/console_writer.sv
// Write side of the text console: byte stream in, character RAM writes out, with CR/LF/BS/FF handling.
// Define CONSOLE_CLEAR_ON_RESET_EN to blank the whole screen after every reset.
module console_writer
    import console_pkg::*;
(
    input  logic              writeClock,
    input  logic              resetN,
    input  logic [7:0]        byteIn,
    input  logic              byteValid,
    output logic              byteReady,
    output logic [ADDR_W-1:0] addrWChar,
    output logic [7:0]        dataWChar,
    output logic              weChar,
    output logic [COL_W-1:0]  cursorCol,
    output logic [ROW_W-1:0]  cursorRow,
    output logic              busy
);

`ifdef CONSOLE_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLEAR_ALL;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t            state;
    logic [ADDR_W-1:0] clearCnt;
    logic [ADDR_W-1:0] rowBase;
    logic              lastCol;
    logic              accept;
    logic              incC, decC, crC, nlC, homeC;

    assign byteReady = (state == IDLE);
    assign busy      = ~byteReady;
    assign accept    = byteValid & byteReady;

    always_comb begin
        incC  = 1'b0;
        decC  = 1'b0;
        crC   = 1'b0;
        nlC   = 1'b0;
        homeC = 1'b0;
        if (accept) begin
            unique case (byteIn)
                CHAR_CR: crC   = 1'b1;
                CHAR_LF: nlC   = 1'b1;
                CHAR_BS: decC  = 1'b1;
                CHAR_FF: homeC = 1'b1;
                default: incC  = 1'b1;
            endcase
        end
    end

    console_cursor cursor (
        .writeClock (writeClock),
        .resetN     (resetN),
        .inc        (incC),
        .dec        (decC),
        .cr         (crC),
        .newLine    (nlC),
        .home       (homeC),
        .col        (cursorCol),
        .row        (cursorRow),
        .rowBase    (rowBase),
        .lastCol    (lastCol)
    );

    // Clear writes trail the state by one cycle, so the wrapping character's write never collides with them
    always_ff @(posedge writeClock or negedge resetN) begin
        if (!resetN) begin
            state     <= RESET_STATE;
            clearCnt  <= '0;
            weChar    <= 1'b0;
            addrWChar <= '0;
            dataWChar <= '0;
        end else begin
            weChar <= 1'b0;
            unique case (state)
                IDLE: begin
                    clearCnt <= '0;
                    if (incC) begin
                        weChar    <= 1'b1;
                        addrWChar <= rowBase + ADDR_W'(cursorCol);
                        dataWChar <= byteIn;
                        if (lastCol) state <= CLEAR_ROW;
                    end else if (decC && (cursorCol != '0)) begin
                        weChar    <= 1'b1;
                        addrWChar <= rowBase + ADDR_W'(cursorCol) - ADDR_W'(1);
                        dataWChar <= BLANK_CHAR;
                    end else if (nlC) begin
                        state <= CLEAR_ROW;
                    end else if (homeC) begin
                        state <= CLEAR_ALL;
                    end
                end
                CLEAR_ROW: begin
                    weChar    <= 1'b1;
                    addrWChar <= rowBase + clearCnt;
                    dataWChar <= BLANK_CHAR;
                    if (clearCnt == ROW_CLEAR_LAST) state <= IDLE;
                    else                            clearCnt <= clearCnt + ADDR_W'(1);
                end
                CLEAR_ALL: begin
                    weChar    <= 1'b1;
                    addrWChar <= clearCnt;
                    dataWChar <= BLANK_CHAR;
                    if (clearCnt == ALL_CLEAR_LAST) state <= IDLE;
                    else                            clearCnt <= clearCnt + ADDR_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_console_writer.sv
// Bench for console_writer: screen-level model (cursor, expected write list, ready countdown) plus directed literal checks.
module tb_console_writer;

    logic        writeClock = 1'b0;
    logic        resetN     = 1'b1;
    logic [7:0]  byteIn     = 8'h00;
    logic        byteValid  = 1'b0;
    logic        byteReady;
    logic [12:0] addrWChar;
    logic [7:0]  dataWChar;
    logic        weChar;
    logic [6:0]  cursorCol;
    logic [5:0]  cursorRow;
    logic        busy;

    console_writer dut (
        .writeClock (writeClock),
        .resetN     (resetN),
        .byteIn     (byteIn),
        .byteValid  (byteValid),
        .byteReady  (byteReady),
        .addrWChar  (addrWChar),
        .dataWChar  (dataWChar),
        .weChar     (weChar),
        .cursorCol  (cursorCol),
        .cursorRow  (cursorRow),
        .busy       (busy)
    );

    always #5 writeClock = ~writeClock;

    localparam int M_COLS = 100;
    localparam int M_ROWS = 60;

    int nChecks = 0;
    int nPass   = 0;

    int mCol, mRow, mClear;
    bit expWrite, expNoWrite;
    int qAddr[$];
    int qData[$];

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic pushWrite(input int a, input int d);
        qAddr.push_back(a);
        qData.push_back(d);
    endtask

    task automatic pushRowClear(input int r);
        for (int i = 0; i < M_COLS; i++) pushWrite(r * M_COLS + i, 32);
    endtask

    task automatic modelReset();
        mCol = 0; mRow = 0; mClear = 0;
        expWrite = 0; expNoWrite = 0;
        qAddr.delete();
        qData.delete();
`ifdef CONSOLE_CLEAR_ON_RESET_EN
        for (int i = 0; i < M_COLS * M_ROWS; i++) pushWrite(i, 32);
        mClear = M_COLS * M_ROWS;
`endif
    endtask

    task automatic newRow();
        mCol = 0;
        mRow = (mRow + 1) % M_ROWS;
        pushRowClear(mRow);
        mClear = M_COLS;
    endtask

    task automatic modelAccept(input logic [7:0] b);
        case (b)
            8'h0D: begin mCol = 0; expNoWrite = 1; end
            8'h0A: newRow();
            8'h08: begin
                if (mCol > 0) begin
                    mCol--;
                    pushWrite(mRow * M_COLS + mCol, 32);
                    expWrite = 1;
                end else expNoWrite = 1;
            end
            8'h0C: begin
                mCol = 0; mRow = 0;
                for (int i = 0; i < M_COLS * M_ROWS; i++) pushWrite(i, 32);
                mClear = M_COLS * M_ROWS;
            end
            default: begin
                pushWrite(mRow * M_COLS + mCol, int'(b));
                expWrite = 1;
                if (mCol < M_COLS - 1) mCol++;
                else newRow();
            end
        endcase
    endtask

    task automatic compareAll();
        int a, d;
        chk("ready", int'(byteReady), int'(mClear == 0));
        chk("busy", int'(busy), int'(mClear != 0));
        chk("cursorCol", int'(cursorCol), mCol);
        chk("cursorRow", int'(cursorRow), mRow);
        if (expWrite)   chk("write_next_cycle", int'(weChar), 1);
        if (expNoWrite) chk("no_write", int'(weChar), 0);
        if (weChar) begin
            if (qAddr.size() == 0) begin
                chk("unexpected_write", int'(weChar), 0);
            end else begin
                a = qAddr.pop_front();
                d = qData.pop_front();
                chk("addrWChar", int'(addrWChar), a);
                chk("dataWChar", int'(dataWChar), d);
            end
        end
    endtask

    // One clock: drive inputs, advance the model, then check outputs at the next falling edge
    task automatic step(input bit v, input logic [7:0] b);
        byteValid  = v;
        byteIn     = b;
        expWrite   = 0;
        expNoWrite = 0;
        if (mClear == 0) begin
            if (v) modelAccept(b);
        end else begin
            mClear--;
        end
        @(negedge writeClock);
        compareAll();
    endtask

    task automatic waitReady(input int budget, output int lowCycles);
        lowCycles = 0;
        while (!byteReady && lowCycles < budget) begin
            step(1'b0, 8'h00);
            lowCycles++;
        end
    endtask

    task automatic applyReset();
        byteValid = 1'b0;
        byteIn    = 8'h00;
        @(negedge writeClock);
        resetN = 1'b0;
        #1;
        chk("reset_weChar", int'(weChar), 0);
        chk("reset_addr", int'(addrWChar), 0);
        chk("reset_data", int'(dataWChar), 0);
        chk("reset_col", int'(cursorCol), 0);
        chk("reset_row", int'(cursorRow), 0);
        @(negedge writeClock);
        @(negedge writeClock);
        resetN = 1'b1;
        modelReset();
    endtask

    function automatic logic [7:0] randPrintable();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D) b = 8'h7E;
        return b;
    endfunction

    initial begin
        int cnt;
        int r;
        int ffLeft;
        logic [7:0] b;

        #2;
        applyReset();
`ifdef CONSOLE_CLEAR_ON_RESET_EN
        chk("reset_ready_low", int'(byteReady), 0);
        waitReady(7000, cnt);
        chk("reset_clear_cycles", cnt, 6000);
`else
        chk("reset_ready_high", int'(byteReady), 1);
`endif

        // Back-to-back printables from the home position
        step(1'b1, 8'h41);
        chk("A_we", int'(weChar), 1);
        chk("A_addr", int'(addrWChar), 0);
        chk("A_data", int'(dataWChar), 8'h41);
        step(1'b1, 8'h42);
        chk("B_we", int'(weChar), 1);
        chk("B_addr", int'(addrWChar), 1);
        chk("B_data", int'(dataWChar), 8'h42);
        step(1'b0, 8'h00);
        chk("AB_col", int'(cursorCol), 2);
        chk("AB_row", int'(cursorRow), 0);

        // LF from column 5
        step(1'b1, 8'h63);
        step(1'b1, 8'h64);
        step(1'b1, 8'h65);
        chk("pre_lf_col", int'(cursorCol), 5);
        step(1'b1, 8'h0A);
        chk("lf_col", int'(cursorCol), 0);
        chk("lf_row", int'(cursorRow), 1);
        waitReady(200, cnt);
        chk("lf_ready_low", cnt, 100);
        step(1'b1, 8'h58);
        chk("X_addr", int'(addrWChar), 100);
        chk("X_data", int'(dataWChar), 8'h58);

        // Walk down to the last row, then fill it to force the wrap to row 0
        step(1'b1, 8'h0D);
        for (int i = 0; i < 58; i++) begin
            step(1'b1, 8'h0A);
            waitReady(200, cnt);
        end
        chk("row59", int'(cursorRow), 59);
        for (int i = 0; i < 100; i++) step(1'b1, 8'(8'h61 + i % 26));
        chk("last_cell_addr", int'(addrWChar), 5999);
        chk("wrap_col", int'(cursorCol), 0);
        chk("wrap_row", int'(cursorRow), 0);
        waitReady(200, cnt);
        chk("wrap_ready_low", cnt, 100);

        // Backspace at column 0, backspace mid-row, CR from column 40
        step(1'b1, 8'h08);
        chk("bs0_we", int'(weChar), 0);
        chk("bs0_col", int'(cursorCol), 0);
        step(1'b1, 8'h70);
        step(1'b1, 8'h71);
        step(1'b1, 8'h72);
        step(1'b1, 8'h08);
        chk("bs_we", int'(weChar), 1);
        chk("bs_addr", int'(addrWChar), 2);
        chk("bs_data", int'(dataWChar), 8'h20);
        chk("bs_col", int'(cursorCol), 2);
        for (int i = 0; i < 38; i++) step(1'b1, 8'h2A);
        chk("pre_cr_col", int'(cursorCol), 40);
        step(1'b1, 8'h0D);
        chk("cr_we", int'(weChar), 0);
        chk("cr_col", int'(cursorCol), 0);

        // Form feed: full-screen clear
        step(1'b1, 8'h51);
        step(1'b1, 8'h0C);
        waitReady(7000, cnt);
        chk("ff_ready_low", cnt, 6000);
        chk("ff_col", int'(cursorCol), 0);
        chk("ff_row", int'(cursorRow), 0);
        chk("ff_queue_drained", qAddr.size(), 0);

        // Reset in the middle of a full clear
        step(1'b1, 8'h0C);
        for (int i = 0; i < 50; i++) step(1'b0, 8'h00);
        chk("midclear_we", int'(weChar), 1);
        applyReset();
`ifdef CONSOLE_CLEAR_ON_RESET_EN
        waitReady(7000, cnt);
        chk("reset2_clear_cycles", cnt, 6000);
`else
        chk("reset2_ready", int'(byteReady), 1);
`endif

        // Randomized traffic
        ffLeft = 1;
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = randPrintable();
            else if (r < 80) b = 8'h0D;
            else if (r < 89) b = 8'h08;
            else if (r < 97) b = 8'h0A;
            else if (ffLeft > 0 && r == 99) begin
                b = 8'h0C;
                ffLeft--;
            end else b = 8'h5A;
            step($urandom_range(0, 3) != 0, b);
        end
        waitReady(7000, cnt);
        step(1'b0, 8'h00);
        chk("final_queue_drained", qAddr.size(), 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
